noise_gen_mc: RTL
=================

Name: noise_gen_mc

Overview:
- Parametrised multi-channel Gaussian noise source; next generation of the single-channel urng/addr/transform chain.
- Each of N_CH channels runs its own xorshift32 uniform generator.
- Each output sample is the sum of K uniforms (central-limit approximation), re-centred to a signed zero-mean value.
- All channels advance in lockstep. Results are offered as one vector word on a valid/ready interface, with burst or continuous mode.

Parameters:
- N_CH, 4: number of independent noise channels (1..16).
- U_W, 12: uniform width; top U_W bits of the xorshift32 state (4..16).
- K, 4: uniforms summed per sample (1..16).
- SW (localparam): U_W + $clog2(K+1); signed sample width.

Ports:
- CK, in, 1: clock.
- RB, in, 1: synchronous active-high reset.
- ST, in, 1: start pulse; loads seeds and burst length, begins generation.
- SP, in, 1: stop request; aborts at the next sample boundary.
- seed, in, 32: base seed, sampled on ST.
- burst, in, 16: number of vector samples to produce; 0 means continuous. Sampled on ST.
- out_data, out, N_CH*SW: channel c occupies bits [c*SW +: SW], two's complement.
- out_valid, out, 1: out_data holds a sample.
- out_ready, in, 1: consumer accepts a sample when out_valid && out_ready.
- busy, out, 1: high in any state except IDLE.
- done, out, 1: one-cycle pulse when a burst completes or a stop takes effect.

Behaviour:
- Reset (RB high at a CK edge):
  - State returns to IDLE.
  - out_data=0, out_valid=0, busy=0, done=0.
  - Channel states, accumulators and counters are cleared.
  - Reset overrides ST in the same cycle, and aborts any operation in progress with no done pulse.
- IDLE:
  - ST=1 moves to SEED. All other inputs are ignored.
- SEED (1 cycle):
  - Channel c state = seed ^ (c * 32'h9E3779B9), with a 0 result replaced by 32'h1.
  - Latch burst. Clear the sample counter and accumulators. Next state is ACCUM.
- ACCUM (exactly K cycles):
  - Each cycle, every channel steps xorshift32: x^=x<<13; x^=x>>17; x^=x<<5 (32-bit truncation).
  - Add the top U_W bits of the new state (unsigned) to that channel's accumulator.
  - Accumulator width is SW; no overflow is possible.
  - After the K-th step, out_data channel c = acc_c - K*2^(U_W-1), signed SW bits.
  - Then set out_valid=1 and go to HOLD.
- HOLD:
  - out_data stays stable and out_valid stays 1 until handshake; generators stall (no state steps).
  - On handshake: out_valid=0 on the next cycle and the sample counter increments.
  - Next state is IDLE with done=1 if (burst!=0 and count==burst) or SP has been latched. Otherwise clear the accumulators and go to ACCUM.
- Latency:
  - ST to first out_valid = K+1 cycles (ST cycle, 1 SEED cycle, K ACCUM cycles; out_valid visible at edge K+2).
  - Sustained throughput with out_ready held at 1: one sample per K+1 cycles.
- SP:
  - Latched (sticky) in any non-IDLE state; cleared in IDLE.
  - Takes effect only after the current sample's handshake, so a sample in flight is never dropped.
  - SP in IDLE is ignored.
- ST while busy is ignored; no re-seed.
- Continuous mode (burst=0): the sample counter wraps at 2^16 and never terminates; only SP ends the run.
- done and out_valid are never high in the same cycle.
- Output range per channel is [-K*2^(U_W-1), K*(2^(U_W-1)-1)].
  - Defaults: [-8192, +8188].

Test Plan:
- Reset/idle: hold RB=1 for 2 cycles, then release. Expect all outputs 0 and busy=0. Pulse SP alone; nothing changes.
- Known vector:
  - Setup: N_CH=1, U_W=12, K=2, seed=0, burst=1, out_ready=1, pulse ST.
  - Channel 0 seed becomes 1, giving states 0x00042021 and 0x04080601, i.e. uniforms 0 and 64.
  - Expect out_data = 64-4096 = -4032 (14'h3040).
  - Expect out_valid at the 4th edge after ST, then done pulse, busy=0.
- Backpressure: defaults, burst=3, out_ready=0 for 20 cycles after the first out_valid. Expect out_data stable and channel states frozen. Release; expect exactly 3 handshakes, samples matching a reference model, then done.
- Stop mid-run: burst=0. Assert SP during ACCUM of sample 5. Expect sample 5 still delivered, then done, IDLE; no sample 6.
- Reset mid-operation: RB=1 during HOLD. Expect out_valid=0 next cycle, no done. A fresh ST with the same seed reproduces an identical sequence.
- Statistics: defaults, seed=32'hDEADBEEF, continuous, 10000 samples per channel. Per-channel mean within ±64 and std dev within 5% of sqrt(K*(2^(2U_W)-1)/12) ≈ 2365. Channels pairwise uncorrelated (|r|<0.05).

Source files
------------

// File: rtl/noise_gen_mc.sv
// Multi-channel Gaussian noise source: each channel sums K xorshift32 uniforms,
// re-centres the sum, and all channels are offered as one vector over valid/ready.

module noise_gen_lane #(
    parameter int U_W = 12,
    parameter int K   = 4,
    parameter int SW  = 15
) (
    input  logic          CK,
    input  logic          RB,
    input  logic          i_load,
    input  logic [31:0]   i_seed,
    input  logic          i_clr,
    input  logic          i_step,
    input  logic          i_cap,
    output logic [SW-1:0] o_data
);
    localparam logic [SW-1:0] OFFSET = SW'(K * (2 ** (U_W - 1)));

    logic [31:0]   r_x;
    logic [SW-1:0] r_acc;
    logic [SW-1:0] r_out;
    logic [31:0]   w_x1;
    logic [31:0]   w_x2;
    logic [31:0]   w_x3;
    logic [SW-1:0] w_sum;

    always_comb begin
        w_x1  = r_x ^ (r_x << 13);
        w_x2  = w_x1 ^ (w_x1 >> 17);
        w_x3  = w_x2 ^ (w_x2 << 5);
        w_sum = r_acc + SW'(w_x3[31 -: U_W]);
    end

    always_ff @(posedge CK) begin
        if (RB) begin
            r_x   <= '0;
            r_acc <= '0;
            r_out <= '0;
        end else begin
            // an all-zero state would lock xorshift at zero forever
            if (i_load) begin
                r_x   <= (i_seed == 32'd0) ? 32'd1 : i_seed;
                r_acc <= '0;
            end else if (i_step) begin
                r_x   <= w_x3;
                r_acc <= w_sum;
            end else if (i_clr) begin
                r_acc <= '0;
            end
            if (i_cap) r_out <= w_sum - OFFSET;
        end
    end

    assign o_data = r_out;
endmodule

module noise_gen_mc #(
    parameter int N_CH = 4,
    parameter int U_W  = 12,
    parameter int K    = 4,
    localparam int SW  = U_W + $clog2(K + 1)
) (
    input  logic             CK,
    input  logic             RB,
    input  logic             ST,
    input  logic             SP,
    input  logic [31:0]      seed,
    input  logic [15:0]      burst,
    output logic [N_CH*SW-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);
    localparam int KW = $clog2(K + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEED, S_ACCUM, S_HOLD} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [KW-1:0] r_k;
    logic [31:0]   r_seed;
    logic [15:0]   r_burst;
    logic [15:0]   r_cnt;
    logic          r_sp;
    logic          r_valid;
    logic          r_done;
    logic          w_load;
    logic          w_step;
    logic          w_cap;
    logic          w_clr;
    logic          w_hs;
    logic          w_fin;

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        w_cap  = 1'b0;
        w_clr  = 1'b0;
        w_hs   = 1'b0;
        w_fin  = 1'b0;
        case (r_state)
            S_IDLE:  if (ST) w_next = S_SEED;
            S_SEED: begin
                w_load = 1'b1;
                w_next = S_ACCUM;
            end
            S_ACCUM: begin
                w_step = 1'b1;
                if (r_k == KW'(K - 1)) begin
                    w_cap  = 1'b1;
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                // a stop only ends the run once the pending sample has been taken
                if (r_valid && out_ready) begin
                    w_hs = 1'b1;
                    if ((r_burst != '0 && (r_cnt + 16'd1) == r_burst) || r_sp || SP) begin
                        w_fin  = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_clr  = 1'b1;
                        w_next = S_ACCUM;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RB) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_seed  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_sp    <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_fin;
            if (r_state == S_IDLE && ST) begin
                r_seed  <= seed;
                r_burst <= burst;
            end
            if (w_load)    r_cnt <= '0;
            else if (w_hs) r_cnt <= r_cnt + 16'd1;
            r_k <= (w_step && !w_cap) ? r_k + KW'(1) : '0;
            if (w_cap)     r_valid <= 1'b1;
            else if (w_hs) r_valid <= 1'b0;
            r_sp <= (r_state == S_IDLE) ? 1'b0 : (r_sp | SP);
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        localparam logic [31:0] MIX = 32'(c) * 32'h9E3779B9;
        noise_gen_lane #(.U_W(U_W), .K(K), .SW(SW)) u_lane (
            .CK     (CK),
            .RB     (RB),
            .i_load (w_load),
            .i_seed (r_seed ^ MIX),
            .i_clr  (w_clr),
            .i_step (w_step),
            .i_cap  (w_cap),
            .o_data (out_data[c*SW +: SW])
        );
    end

    assign out_valid = r_valid;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
endmodule
